// File: rtl/ex_stage_pkg.sv
// Shared execute-stage definitions: ALU operation/class codes, datapath widths
// and the divider state encoding.
package ex_stage_pkg;

  localparam int ALUOpWidth   = 8;
  localparam int ALUSelWidth  = 3;
  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;

  localparam logic [ALUSelWidth-1:0] ALU_SEL_NOP        = 3'd0;
  localparam logic [ALUSelWidth-1:0] ALU_SEL_LOGIC      = 3'd1;
  localparam logic [ALUSelWidth-1:0] ALU_SEL_SHIFT      = 3'd2;
  localparam logic [ALUSelWidth-1:0] ALU_SEL_ARITHMETIC = 3'd3;

  localparam logic [ALUOpWidth-1:0] ALU_NOP    = 8'h00;
  localparam logic [ALUOpWidth-1:0] ALU_AND    = 8'h01;
  localparam logic [ALUOpWidth-1:0] ALU_OR     = 8'h02;
  localparam logic [ALUOpWidth-1:0] ALU_XOR    = 8'h03;
  localparam logic [ALUOpWidth-1:0] ALU_NOR    = 8'h04;
  localparam logic [ALUOpWidth-1:0] ALU_ANDI   = 8'h05;
  localparam logic [ALUOpWidth-1:0] ALU_ORI    = 8'h06;
  localparam logic [ALUOpWidth-1:0] ALU_XORI   = 8'h07;
  localparam logic [ALUOpWidth-1:0] ALU_SLLW   = 8'h08;
  localparam logic [ALUOpWidth-1:0] ALU_SRLW   = 8'h09;
  localparam logic [ALUOpWidth-1:0] ALU_SRAW   = 8'h0A;
  localparam logic [ALUOpWidth-1:0] ALU_SLLIW  = 8'h0B;
  localparam logic [ALUOpWidth-1:0] ALU_SRLIW  = 8'h0C;
  localparam logic [ALUOpWidth-1:0] ALU_SRAIW  = 8'h0D;
  localparam logic [ALUOpWidth-1:0] ALU_ADDW   = 8'h10;
  localparam logic [ALUOpWidth-1:0] ALU_ADDIW  = 8'h11;
  localparam logic [ALUOpWidth-1:0] ALU_SUBW   = 8'h12;
  localparam logic [ALUOpWidth-1:0] ALU_SLT    = 8'h13;
  localparam logic [ALUOpWidth-1:0] ALU_SLTI   = 8'h14;
  localparam logic [ALUOpWidth-1:0] ALU_SLTU   = 8'h15;
  localparam logic [ALUOpWidth-1:0] ALU_SLTUI  = 8'h16;
  localparam logic [ALUOpWidth-1:0] ALU_MULW   = 8'h17;
  localparam logic [ALUOpWidth-1:0] ALU_MULHW  = 8'h18;
  localparam logic [ALUOpWidth-1:0] ALU_MULHWU = 8'h19;
  localparam logic [ALUOpWidth-1:0] ALU_DIVW   = 8'h1A;
  localparam logic [ALUOpWidth-1:0] ALU_MODW   = 8'h1B;
  localparam logic [ALUOpWidth-1:0] ALU_DIVWU  = 8'h1C;
  localparam logic [ALUOpWidth-1:0] ALU_MODWU  = 8'h1D;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// with the sign fix-up applied on the registered result.
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_op,
  input  logic              flush,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] q_reg, q_next;
  logic [DATA_W-1:0] r_reg, r_next;
  logic [DATA_W-1:0] d_reg, d_next;
  logic              neg_q_reg, neg_q_next;
  logic              neg_r_reg, neg_r_next;
  logic              dz_reg, dz_next;

  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   trial;

  // The partial remainder stays below the divisor, so one extra bit covers the shift.
  assign shifted = {r_reg, q_reg[DATA_W-1]};
  assign trial   = shifted - {1'b0, d_reg};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= DIV_IDLE;
      cnt_reg   <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      d_reg     <= d_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      dz_reg    <= dz_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    d_next     = d_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    dz_next    = dz_reg;
    case (state_reg)
      DIV_IDLE: begin
        if (start && !flush) begin
          neg_q_next = signed_op & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
          neg_r_next = signed_op & dividend[DATA_W-1];
          cnt_next   = '0;
          if (divisor == '0) begin
            q_next     = '1;
            r_next     = dividend;
            d_next     = '0;
            dz_next    = 1'b1;
            state_next = DIV_DONE;
          end else begin
            q_next     = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
            d_next     = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;
            r_next     = '0;
            dz_next    = 1'b0;
            state_next = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (!trial[DATA_W]) begin
          r_next = trial[DATA_W-1:0];
          q_next = {q_reg[DATA_W-2:0], 1'b1};
        end else begin
          r_next = shifted[DATA_W-1:0];
          q_next = {q_reg[DATA_W-2:0], 1'b0};
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_LAST) begin
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
    if (flush) begin
      state_next = DIV_IDLE;
    end
  end

  assign busy      = (state_reg == DIV_BUSY);
  assign done      = (state_reg == DIV_DONE);
  assign quotient  = (neg_q_reg && !dz_reg) ? -q_reg : q_reg;
  assign remainder = (neg_r_reg && !dz_reg) ? -r_reg : r_reg;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle logic/shift/arithmetic/multiply results, the
// iterative divider, and the write-back/forwarding triple with stall request.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_i,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [DATA_W-1:0]   reg1_i,
  input  logic [DATA_W-1:0]   reg2_i,
  input  logic [4:0]          reg_write_addr_i,
  input  logic                reg_write_en_i,
  output logic                reg_write_en_o,
  output logic [4:0]          reg_write_addr_o,
  output logic [DATA_W-1:0]   reg_write_data_o,
  output logic                pause_ex
);

  logic [4:0]          shamt;
  logic [2*DATA_W-1:0] prod_u;
  logic [DATA_W-1:0]   mulh_s;
  logic                is_arith, is_div, is_mod, div_signed;
  logic                div_busy, div_done;
  logic [DATA_W-1:0]   div_q, div_r;
  logic [DATA_W-1:0]   alu_data;
  logic                pause_core;

  assign shamt  = reg2_i[4:0];
  assign prod_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};
  // Signed high half derived from the unsigned product by subtracting the
  // contribution of each operand's sign bit.
  assign mulh_s = prod_u[2*DATA_W-1:DATA_W]
                - (reg1_i[DATA_W-1] ? reg2_i : '0)
                - (reg2_i[DATA_W-1] ? reg1_i : '0);

  assign is_arith   = (alusel_i == ALUSEL_W'(ALU_SEL_ARITHMETIC));
  assign is_mod     = (aluop_i == ALUOP_W'(ALU_MODW)) || (aluop_i == ALUOP_W'(ALU_MODWU));
  assign div_signed = (aluop_i == ALUOP_W'(ALU_DIVW)) || (aluop_i == ALUOP_W'(ALU_MODW));
  assign is_div     = is_arith && (div_signed || is_mod || (aluop_i == ALUOP_W'(ALU_DIVWU)));

  div_iter #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div),
    .signed_op (div_signed),
    .flush     (flush_i),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );

  always_comb begin
    alu_data = '0;
    case (alusel_i)
      ALUSEL_W'(ALU_SEL_LOGIC): begin
        case (aluop_i)
          ALUOP_W'(ALU_AND), ALUOP_W'(ALU_ANDI): alu_data = reg1_i & reg2_i;
          ALUOP_W'(ALU_OR),  ALUOP_W'(ALU_ORI):  alu_data = reg1_i | reg2_i;
          ALUOP_W'(ALU_XOR), ALUOP_W'(ALU_XORI): alu_data = reg1_i ^ reg2_i;
          ALUOP_W'(ALU_NOR):                     alu_data = ~(reg1_i | reg2_i);
          default:                               alu_data = '0;
        endcase
      end
      ALUSEL_W'(ALU_SEL_SHIFT): begin
        case (aluop_i)
          ALUOP_W'(ALU_SLLW), ALUOP_W'(ALU_SLLIW): alu_data = reg1_i << shamt;
          ALUOP_W'(ALU_SRLW), ALUOP_W'(ALU_SRLIW): alu_data = reg1_i >> shamt;
          ALUOP_W'(ALU_SRAW), ALUOP_W'(ALU_SRAIW): alu_data = $unsigned($signed(reg1_i) >>> shamt);
          default:                                 alu_data = '0;
        endcase
      end
      ALUSEL_W'(ALU_SEL_ARITHMETIC): begin
        case (aluop_i)
          ALUOP_W'(ALU_ADDW), ALUOP_W'(ALU_ADDIW): alu_data = reg1_i + reg2_i;
          ALUOP_W'(ALU_SUBW):                      alu_data = reg1_i - reg2_i;
          ALUOP_W'(ALU_SLT), ALUOP_W'(ALU_SLTI):
            alu_data = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
          ALUOP_W'(ALU_SLTU), ALUOP_W'(ALU_SLTUI):
            alu_data = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
          ALUOP_W'(ALU_MULW):   alu_data = prod_u[DATA_W-1:0];
          ALUOP_W'(ALU_MULHW):  alu_data = mulh_s;
          ALUOP_W'(ALU_MULHWU): alu_data = prod_u[2*DATA_W-1:DATA_W];
          ALUOP_W'(ALU_DIVW), ALUOP_W'(ALU_DIVWU),
          ALUOP_W'(ALU_MODW), ALUOP_W'(ALU_MODWU):
            alu_data = div_done ? (is_mod ? div_r : div_q) : '0;
          default: alu_data = '0;
        endcase
      end
      default: alu_data = '0;
    endcase
  end

  // A division stalls from its first cycle in IDLE until DONE, unless killed.
  assign pause_core = !flush_i && (div_busy || (is_div && !div_done));

  assign pause_ex         = rst & pause_core;
  assign reg_write_en_o   = rst & reg_write_en_i & ~flush_i & ~pause_core;
  assign reg_write_addr_o = rst ? reg_write_addr_i : 5'd0;
  assign reg_write_data_o = rst ? alu_data : '0;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage: single-cycle ALU results, divider timing,
// divide-by-zero, overflow case, back-to-back divides, flush and mid-run reset.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic [7:0]  aluop_i = 8'h00;
  logic [2:0]  alusel_i = 3'd0;
  logic [31:0] reg1_i = 32'h0;
  logic [31:0] reg2_i = 32'h0;
  logic [4:0]  reg_write_addr_i = 5'd0;
  logic        reg_write_en_i = 1'b0;
  logic        reg_write_en_o;
  logic [4:0]  reg_write_addr_o;
  logic [31:0] reg_write_data_o;
  logic        pause_ex;

  int tests = 0;
  int fails = 0;

  ex_stage dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush_i),
    .aluop_i          (aluop_i),
    .alusel_i         (alusel_i),
    .reg1_i           (reg1_i),
    .reg2_i           (reg2_i),
    .reg_write_addr_i (reg_write_addr_i),
    .reg_write_en_i   (reg_write_en_i),
    .reg_write_en_o   (reg_write_en_o),
    .reg_write_addr_o (reg_write_addr_o),
    .reg_write_data_o (reg_write_data_o),
    .pause_ex         (pause_ex)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] sel, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr, input logic en);
    alusel_i = sel; aluop_i = op; reg1_i = a; reg2_i = b;
    reg_write_addr_i = addr; reg_write_en_i = en;
    #1;
  endtask

  // Counts cycles with pause_ex high; stops at 100 so a stuck divider still ends.
  task automatic count_pause(output int n);
    n = 0;
    while (pause_ex === 1'b1 && n < 100) begin
      n++;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(ALU_SEL_ARITHMETIC, ALU_ADDW, 32'd2, 32'd3, 5'd7, 1'b1);
    tests++;
    if ({reg_write_en_o, reg_write_addr_o, reg_write_data_o, pause_ex} !== 39'h0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%h pause=%b, want all 0",
               reg_write_en_o, reg_write_addr_o, reg_write_data_o, pause_ex);
    end
    $display("[TB] reset: outputs en=%b addr=%0d data=%h pause=%b",
             reg_write_en_o, reg_write_addr_o, reg_write_data_o, pause_ex);
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_single_cycle();
    logic [2:0]  sel_t [10] = '{ALU_SEL_ARITHMETIC, ALU_SEL_SHIFT, ALU_SEL_ARITHMETIC,
                                 ALU_SEL_ARITHMETIC, ALU_SEL_ARITHMETIC, ALU_SEL_ARITHMETIC,
                                 ALU_SEL_ARITHMETIC, ALU_SEL_LOGIC, ALU_SEL_ARITHMETIC, ALU_SEL_NOP};
    logic [7:0]  op_t  [10] = '{ALU_ADDW, ALU_SRAW, ALU_MULHW, ALU_MULHWU, ALU_SUBW,
                                 ALU_SLT, ALU_SLTU, ALU_NOR, 8'hEE, ALU_ADDW};
    logic [31:0] a_t   [10] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,
                                 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0F0F0000, 32'h12345678, 32'h1};
    logic [31:0] b_t   [10] = '{32'h1, 32'h21, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,
                                 32'h1, 32'h1, 32'h00000F0F, 32'h1, 32'h1};
    logic [31:0] exp_t [10] = '{32'h80000000, 32'hC0000000, 32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF,
                                 32'h1, 32'h0, 32'hF0F0F0F0, 32'h0, 32'h0};
    for (int i = 0; i < 10; i++) begin
      cyc();
      drive(sel_t[i], op_t[i], a_t[i], b_t[i], 5'd5, 1'b1);
      tests++;
      if (reg_write_data_o !== exp_t[i] || reg_write_en_o !== 1'b1 ||
          reg_write_addr_o !== 5'd5 || pause_ex !== 1'b0) begin
        fails++;
        $display("FAIL alu_vec%0d: got data=%h en=%b addr=%0d pause=%b, want data=%h en=1 addr=5 pause=0",
                 i, reg_write_data_o, reg_write_en_o, reg_write_addr_o, pause_ex, exp_t[i]);
      end
      $display("[TB] alu op=%h a=%h b=%h -> data=%h", op_t[i], a_t[i], b_t[i], reg_write_data_o);
    end
    flush_i = 1'b1;
    #1;
    tests++;
    if (reg_write_en_o !== 1'b0) begin
      fails++;
      $display("FAIL alu_flush_en: got en=%b, want 0", reg_write_en_o);
    end
    $display("[TB] alu flush: en=%b", reg_write_en_o);
    flush_i = 1'b0;
  endtask

  task automatic test_divw_modw();
    int n;
    logic [7:0]  op_t  [2] = '{ALU_DIVW, ALU_MODW};
    logic [31:0] exp_t [2] = '{32'hFFFFFFFD, 32'hFFFFFFFF};
    for (int i = 0; i < 2; i++) begin
      cyc();
      drive(ALU_SEL_ARITHMETIC, op_t[i], 32'hFFFFFFF9, 32'd2, 5'd3, 1'b1);
      count_pause(n);
      tests++;
      if (n !== 33 || reg_write_data_o !== exp_t[i] || reg_write_en_o !== 1'b1 ||
          reg_write_addr_o !== 5'd3) begin
        fails++;
        $display("FAIL div_signed%0d: got pause=%0d data=%h en=%b addr=%0d, want pause=33 data=%h en=1 addr=3",
                 i, n, reg_write_data_o, reg_write_en_o, reg_write_addr_o, exp_t[i]);
      end
      $display("[TB] op=%h -7/2: pause=%0d data=%h", op_t[i], n, reg_write_data_o);
    end
  endtask

  task automatic test_div_zero();
    int n;
    logic [7:0]  op_t  [2] = '{ALU_DIVWU, ALU_MODWU};
    logic [31:0] exp_t [2] = '{32'hFFFFFFFF, 32'd100};
    for (int i = 0; i < 2; i++) begin
      cyc();
      drive(ALU_SEL_ARITHMETIC, op_t[i], 32'd100, 32'd0, 5'd4, 1'b1);
      count_pause(n);
      tests++;
      if (n !== 1 || reg_write_data_o !== exp_t[i] || reg_write_en_o !== 1'b1) begin
        fails++;
        $display("FAIL div_zero%0d: got pause=%0d data=%h en=%b, want pause=1 data=%h en=1",
                 i, n, reg_write_data_o, reg_write_en_o, exp_t[i]);
      end
      $display("[TB] op=%h 100/0: pause=%0d data=%h", op_t[i], n, reg_write_data_o);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    cyc();
    drive(ALU_SEL_ARITHMETIC, ALU_DIVW, 32'h80000000, 32'hFFFFFFFF, 5'd6, 1'b1);
    count_pause(n);
    tests++;
    if (n !== 33 || reg_write_data_o !== 32'h80000000) begin
      fails++;
      $display("FAIL div_overflow: got pause=%0d data=%h, want pause=33 data=80000000",
               n, reg_write_data_o);
    end
    $display("[TB] divw 80000000/ffffffff: pause=%0d data=%h", n, reg_write_data_o);
    cyc();
    drive(ALU_SEL_ARITHMETIC, ALU_DIVWU, 32'd9, 32'd3, 5'd8, 1'b1);
    tests++;
    if (pause_ex !== 1'b1) begin
      fails++;
      $display("FAIL b2b_start: got pause=%b, want 1", pause_ex);
    end
    count_pause(n);
    tests++;
    if (n !== 33 || reg_write_data_o !== 32'd3 || reg_write_addr_o !== 5'd8) begin
      fails++;
      $display("FAIL b2b_divwu: got pause=%0d data=%h addr=%0d, want pause=33 data=3 addr=8",
               n, reg_write_data_o, reg_write_addr_o);
    end
    $display("[TB] b2b divwu 9/3: pause=%0d data=%h", n, reg_write_data_o);
  endtask

  task automatic test_flush();
    cyc();
    drive(ALU_SEL_ARITHMETIC, ALU_DIVW, 32'd1000, 32'd7, 5'd2, 1'b1);
    for (int i = 0; i < 10; i++) cyc();
    flush_i = 1'b1;
    #1;
    tests++;
    if (pause_ex !== 1'b0 || reg_write_en_o !== 1'b0) begin
      fails++;
      $display("FAIL flush_comb: got pause=%b en=%b, want 0 0", pause_ex, reg_write_en_o);
    end
    cyc();
    flush_i = 1'b0;
    drive(ALU_SEL_NOP, ALU_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    tests++;
    if (pause_ex !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle: got pause=%b, want 0", pause_ex);
    end
    $display("[TB] flush mid-busy: pause after=%b", pause_ex);
  endtask

  task automatic test_reset_mid_busy();
    int n;
    cyc();
    drive(ALU_SEL_ARITHMETIC, ALU_DIVW, 32'd1000, 32'd7, 5'd9, 1'b1);
    for (int i = 0; i < 5; i++) cyc();
    rst = 1'b0;
    #1;
    tests++;
    if ({reg_write_en_o, reg_write_addr_o, reg_write_data_o, pause_ex} !== 39'h0) begin
      fails++;
      $display("FAIL reset_busy: got en=%b addr=%0d data=%h pause=%b, want all 0",
               reg_write_en_o, reg_write_addr_o, reg_write_data_o, pause_ex);
    end
    cyc();
    rst = 1'b1;
    drive(ALU_SEL_ARITHMETIC, ALU_ADDW, 32'd2, 32'd3, 5'd4, 1'b1);
    tests++;
    if (pause_ex !== 1'b0 || reg_write_data_o !== 32'd5) begin
      fails++;
      $display("FAIL reset_idle: got pause=%b data=%h, want 0 00000005", pause_ex, reg_write_data_o);
    end
    cyc();
    drive(ALU_SEL_ARITHMETIC, ALU_DIVW, 32'd1000, 32'd7, 5'd9, 1'b1);
    count_pause(n);
    tests++;
    if (n !== 33 || reg_write_data_o !== 32'd142) begin
      fails++;
      $display("FAIL reset_redo: got pause=%0d data=%h, want pause=33 data=0000008e",
               n, reg_write_data_o);
    end
    $display("[TB] reset mid-busy then divw 1000/7: pause=%0d data=%h", n, reg_write_data_o);
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_divw_modw();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
